pwm_gen: RTL

//  Consumes the divided clock from clk_gen (clk_gen_out) in the fsys domain: synchronises it,

---
 rtl/pwm_gen.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_gen.sv
// ---------------------------------------------------------------------------
// pwm_gen
//   PWM generator clocked by fsys and paced by the divided clock from
//   clk_gen (pwm_clk_in). The divided clock is synchronised into fsys and
//   each rising edge becomes a one-cycle tick. The PWM counter advances once
//   per tick. Period/duty are double-buffered in a shadow register and only
//   reach the active register on a period boundary, so the waveform never
//   glitches mid-period.
//
//   Optional feature macro: PWM_IRQ_EN
//     defined   -> adds pwm_irq_clr (in) and pwm_irq (out), a sticky flag
//                  set by pwm_cyc_done and cleared by pwm_irq_clr
//                  (set wins when both occur in the same cycle).
//     undefined -> those ports and the flag logic are absent.
//
// Ports
//   fsys          in   system clock, rising edge
//   pwm_rst_n     in   asynchronous active-low reset
//   pwm_clk_in    in   divided clock (asynchronous to fsys)
//   pwm_en        in   1 = run, 0 = stop at end of the current period
//   pwm_load      in   pulse: capture pwm_period/pwm_duty into the shadow
//   pwm_period    in   period in ticks (CW bits)
//   pwm_duty      in   high time in ticks (CW bits)
//   pwm_out       out  PWM waveform (registered)
//   pwm_tick      out  one-cycle pulse per pwm_clk_in rising edge
//   pwm_cyc_done  out  one-cycle pulse on every period wrap
//   pwm_busy      out  1 while in LOAD/RUN/STOP
//   pwm_irq_clr   in   (PWM_IRQ_EN only) clear for pwm_irq
//   pwm_irq       out  (PWM_IRQ_EN only) sticky wrap flag
// ---------------------------------------------------------------------------
module pwm_gen #(
    parameter int CW = 8
) (
    input  logic          fsys,
    input  logic          pwm_rst_n,
    input  logic          pwm_clk_in,
    input  logic          pwm_en,
    input  logic          pwm_load,
    input  logic [CW-1:0] pwm_period,
    input  logic [CW-1:0] pwm_duty,
`ifdef PWM_IRQ_EN
    input  logic          pwm_irq_clr,
    output logic          pwm_irq,
`endif
    output logic          pwm_out,
    output logic          pwm_tick,
    output logic          pwm_cyc_done,
    output logic          pwm_busy
);

    typedef struct packed {
        logic [CW-1:0] period;
        logic [CW-1:0] duty;
    } cfg_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, STOP} state_t;

    // -----------------------------------------------------------------------
    // Synchroniser / edge detect. sync_pipe[1] is the metastability flop;
    // the edge is taken between stages 2 and 3 so only settled values are
    // compared. Runs in every FSM state.
    // -----------------------------------------------------------------------
    logic [3:1] sync_pipe;

    always_ff @(posedge fsys or negedge pwm_rst_n) begin
        if (!pwm_rst_n) begin
            sync_pipe <= '0;
            pwm_tick  <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[2:1], pwm_clk_in};
            pwm_tick  <= sync_pipe[2] & ~sync_pipe[3];
        end
    end

    // -----------------------------------------------------------------------
    // Counter / FSM
    // -----------------------------------------------------------------------
    state_t        state;
    cfg_t          active;
    cfg_t          shadow;
    logic          pending;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          wrap;

    // A zero period never matches cnt==period-1 (that would be all-ones),
    // so it is called out separately: every tick is then a wrap.
    assign wrap    = (active.period == '0) || (cnt == active.period - 1'b1);
    assign cnt_inc = cnt + 1'b1;

    // Output level for a given count under a given configuration. A zero
    // period forces low regardless of duty; duty >= period gives constant high
    // because cnt never reaches period.
    function automatic logic duty_hi(input logic [CW-1:0] c, input cfg_t cfg);
        return (cfg.period != '0) && (c < cfg.duty);
    endfunction

    always_ff @(posedge fsys or negedge pwm_rst_n) begin
        if (!pwm_rst_n) begin
            state        <= IDLE;
            active       <= '0;
            shadow       <= '0;
            pending      <= 1'b0;
            cnt          <= '0;
            pwm_out      <= 1'b0;
            pwm_cyc_done <= 1'b0;
            pwm_busy     <= 1'b0;
        end else begin
            pwm_cyc_done <= 1'b0;

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    pwm_out <= 1'b0;
                    if (pwm_en) begin
                        state    <= LOAD;
                        pwm_busy <= 1'b1;
                    end
                end

                LOAD: begin
                    active   <= shadow;
                    pending  <= 1'b0;
                    cnt      <= '0;
                    state    <= RUN;
                    pwm_busy <= 1'b1;
                    pwm_out  <= duty_hi('0, shadow);
                end

                RUN, STOP: begin
                    if (pwm_tick && wrap) begin
                        cnt          <= '0;
                        pwm_cyc_done <= 1'b1;
                        if (state == STOP) begin
                            // Stopping period finished: park without applying
                            // the shadow; LOAD copies it on the next start.
                            state    <= IDLE;
                            pwm_busy <= 1'b0;
                            pwm_out  <= 1'b0;
                        end else begin
                            if (pending) begin
                                active  <= shadow;
                                pending <= 1'b0;
                                pwm_out <= duty_hi('0, shadow);
                            end else begin
                                pwm_out <= duty_hi('0, active);
                            end
                            if (!pwm_en) state <= STOP;
                        end
                    end else begin
                        if (pwm_tick) begin
                            cnt     <= cnt_inc;
                            pwm_out <= duty_hi(cnt_inc, active);
                        end
                        // Without a wrap, en simply toggles between running
                        // and winding down; the count carries on either way.
                        if (state == RUN && !pwm_en)
                            state <= STOP;
                        else if (state == STOP && pwm_en)
                            state <= RUN;
                    end
                end

                default: begin
                    state    <= IDLE;
                    pwm_busy <= 1'b0;
                    pwm_out  <= 1'b0;
                end
            endcase

            // Placed last so a load in the same cycle as an apply wins the
            // pending flag: the apply took the old shadow, the new one waits.
            if (pwm_load) begin
                shadow  <= '{period: pwm_period, duty: pwm_duty};
                pending <= 1'b1;
            end
        end
    end

`ifdef PWM_IRQ_EN
    // -----------------------------------------------------------------------
    // Sticky wrap flag; a wrap in the same cycle as a clear keeps it set.
    // -----------------------------------------------------------------------
    always_ff @(posedge fsys or negedge pwm_rst_n) begin
        if (!pwm_rst_n)
            pwm_irq <= 1'b0;
        else if (pwm_cyc_done)
            pwm_irq <= 1'b1;
        else if (pwm_irq_clr)
            pwm_irq <= 1'b0;
    end
`endif

endmodule
